// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : dmem_arb_pkg
//  Brief   : Shared types and constants for the data-memory arbiter.
//  Rev     : 1.0  initial release
// ============================================================================
package dmem_arb_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_EXT = 1'b1;

    typedef enum logic {
        ARB      = 1'b0,
        EXT_LOCK = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                  we;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_starve_cnt.sv
`default_nettype none
// ============================================================================
//  Module  : arb_starve_cnt
//  Brief   : Saturating count of refused external cycles with clear and limit.
//  Rev     : 1.0  initial release
// ============================================================================
module arb_starve_cnt #(
    parameter int MAX_WAIT  = 4,
    parameter int CNT_WIDTH = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic limit
);

    localparam logic [CNT_WIDTH-1:0] c_max_wait = CNT_WIDTH'(MAX_WAIT);

    logic [CNT_WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != c_max_wait)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign limit = (r_cnt == c_max_wait);

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : dmem_arbiter
//  Brief   : Shares the single-port data memory between the CPU and an
//            external requester; one grant per cycle, registered read return.
//  Rev     : 1.0  initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = MEM_DATA_W,
    parameter int ADDR_WIDTH = MEM_ADDR_W,
    parameter int MAX_WAIT   = 4,
    parameter int CNT_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  stall,
    input  logic                  ext_req,
    input  logic                  ext_we,
    input  logic                  ext_lock,
    input  logic [ADDR_WIDTH-1:0] ext_addr,
    input  logic [DATA_WIDTH-1:0] ext_wdata,
    output logic                  ext_gnt,
    output logic                  ext_rvalid,
    output logic [DATA_WIDTH-1:0] ext_rdata,
    output logic [ADDR_WIDTH-1:0] mem_A,
    output logic                  mem_WE,
    output logic [DATA_WIDTH-1:0] mem_WD,
    input  logic [DATA_WIDTH-1:0] mem_RD
);

    arb_state_t            r_state;
    logic                  w_limit;
    logic                  w_cpu_gnt;
    logic                  w_ext_gnt;
    logic                  w_owner;
    mem_req_t              w_cpu_side;
    mem_req_t              w_ext_side;
    mem_req_t              w_sel;
    logic                  r_cpu_rvalid;
    logic                  r_ext_rvalid;
    logic [DATA_WIDTH-1:0] r_cpu_rdata;
    logic [DATA_WIDTH-1:0] r_ext_rdata;

    // Grants are gated by rst_n so nothing reaches memory while in reset.
    always_comb begin
        w_ext_gnt = 1'b0;
        if (r_state == EXT_LOCK) begin
            w_ext_gnt = ext_req;
        end else begin
            w_ext_gnt = ext_req & (~cpu_req | w_limit);
        end
        w_ext_gnt = w_ext_gnt & rst_n;
        w_cpu_gnt = cpu_req & ~w_ext_gnt & rst_n;
    end

    arb_starve_cnt #(
        .MAX_WAIT  (MAX_WAIT),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_starve_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_ext_gnt | ~ext_req),
        .inc   ((r_state == ARB) & w_cpu_gnt & ext_req),
        .limit (w_limit)
    );

    always_comb begin
        w_cpu_side = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
        w_ext_side = '{we: ext_we, addr: ext_addr, wdata: ext_wdata};
        w_owner    = w_ext_gnt ? OWNER_EXT : OWNER_CPU;
        w_sel      = (w_owner == OWNER_EXT) ? w_ext_side : w_cpu_side;
    end

    assign mem_A   = w_sel.addr;
    assign mem_WD  = w_sel.wdata;
    assign mem_WE  = (w_cpu_gnt | w_ext_gnt) & w_sel.we;
    assign cpu_gnt = w_cpu_gnt;
    assign ext_gnt = w_ext_gnt;
    assign stall   = cpu_req & ~w_cpu_gnt & rst_n;

    // A locked burst ends after any cycle where the requester drops req or lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB;
        end else begin
            case (r_state)
                ARB: begin
                    if (w_ext_gnt && ext_lock) begin
                        r_state <= EXT_LOCK;
                    end
                end
                EXT_LOCK: begin
                    if (!ext_req || !ext_lock) begin
                        r_state <= ARB;
                    end
                end
                default: r_state <= ARB;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cpu_rvalid <= 1'b0;
            r_ext_rvalid <= 1'b0;
            r_cpu_rdata  <= '0;
            r_ext_rdata  <= '0;
        end else begin
            r_cpu_rvalid <= w_cpu_gnt & ~cpu_we;
            r_ext_rvalid <= w_ext_gnt & ~ext_we;
            if (w_cpu_gnt && !cpu_we) begin
                r_cpu_rdata <= mem_RD;
            end
            if (w_ext_gnt && !ext_we) begin
                r_ext_rdata <= mem_RD;
            end
        end
    end

    assign cpu_rvalid = r_cpu_rvalid;
    assign cpu_rdata  = r_cpu_rdata;
    assign ext_rvalid = r_ext_rvalid;
    assign ext_rdata  = r_ext_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_dmem_arbiter
//  Brief   : Self-checking bench for dmem_arbiter with a small memory model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid, stall;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        ext_req, ext_we, ext_lock, ext_gnt, ext_rvalid;
    logic [31:0] ext_addr, ext_wdata, ext_rdata;
    logic [31:0] mem_A, mem_WD, mem_RD;
    logic        mem_WE;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .MAX_WAIT   (MAX_WAIT),
        .CNT_WIDTH  (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .stall      (stall),
        .ext_req    (ext_req),
        .ext_we     (ext_we),
        .ext_lock   (ext_lock),
        .ext_addr   (ext_addr),
        .ext_wdata  (ext_wdata),
        .ext_gnt    (ext_gnt),
        .ext_rvalid (ext_rvalid),
        .ext_rdata  (ext_rdata),
        .mem_A      (mem_A),
        .mem_WE     (mem_WE),
        .mem_WD     (mem_WD),
        .mem_RD     (mem_RD)
    );

    // 64-word memory; unwritten words read a fixed pattern (word 4 = 0xDEADBEEF).
    logic [31:0] mem [0:63];
    logic [63:0] written = '0;
    logic [5:0]  mem_idx;

    function automatic logic [31:0] dflt(input logic [5:0] idx);
        return (idx == 6'd4) ? 32'hDEADBEEF : ({26'd0, idx} * 32'h01010101);
    endfunction

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        return written[a[7:2]] ? mem[a[7:2]] : dflt(a[7:2]);
    endfunction

    assign mem_idx = mem_A[7:2];
    assign mem_RD  = written[mem_idx] ? mem[mem_idx] : dflt(mem_idx);

    always @(posedge clk) begin
        if (mem_WE) begin
            mem[mem_idx]     <= mem_WD;
            written[mem_idx] <= 1'b1;
        end
    end

    a_ext_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (ext_req && !ext_gnt) |=> ext_req);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        ext_req = 1'b0; ext_we = 1'b0; ext_lock = 1'b0; ext_addr = 32'h0; ext_wdata = 32'h0;
    endtask

    // {cr,cw,er,ew,el} inputs, {cg,eg,st,we} combinational, {crv,erv} registered
    typedef struct packed {
        logic cr, cw, er, ew, el;
        logic cg, eg, st, we;
        logic crv, erv;
    } vec_t;

    vec_t tbl [10];

    bit          e, c, cpu_pend, ext_pend, m_burst;
    int          m_refused, waits;
    bit          exp_crv, exp_erv;
    logic [31:0] exp_crd, exp_erd;

    initial begin
        tbl[0] = 11'b10100_1000_00;
        tbl[1] = 11'b10100_1000_10;
        tbl[2] = 11'b10100_1000_10;
        tbl[3] = 11'b10100_1000_10;
        tbl[4] = 11'b10100_0110_10;
        tbl[5] = 11'b10100_1000_01;
        tbl[6] = 11'b00100_0100_10;
        tbl[7] = 11'b00000_0000_01;
        tbl[8] = 11'b00110_0101_00;
        tbl[9] = 11'b11000_1001_00;

        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1;
        #1;
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_ext_gnt", ext_gnt, 0);
        chk("rst_stall", stall, 0);
        chk("rst_mem_we", mem_WE, 0);
        chk("rst_cpu_rvalid", cpu_rvalid, 0);
        chk("rst_ext_rvalid", ext_rvalid, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_ext_rdata", ext_rdata, 0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;

        // CPU-only read
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = 32'h10;
        #1;
        chk("t1_cpu_gnt", cpu_gnt, 1);
        chk("t1_stall", stall, 0);
        chk("t1_mem_a", mem_A, 32'h10);
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        chk("t1_cpu_rvalid", cpu_rvalid, 1);
        chk("t1_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        @(negedge clk);
        #1;
        chk("t1_rvalid_pulse", cpu_rvalid, 0);

        // Contention / idle / write table
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cpu_req = tbl[i].cr; cpu_we = tbl[i].cw; cpu_addr = 32'h40; cpu_wdata = 32'h1234_0000 + i;
            ext_req = tbl[i].er; ext_we = tbl[i].ew; ext_lock = tbl[i].el;
            ext_addr = 32'h80; ext_wdata = 32'h5678_0000 + i;
            #1;
            chk($sformatf("v%0d_cpu_gnt", i), cpu_gnt, tbl[i].cg);
            chk($sformatf("v%0d_ext_gnt", i), ext_gnt, tbl[i].eg);
            chk($sformatf("v%0d_stall", i), stall, tbl[i].st);
            chk($sformatf("v%0d_mem_we", i), mem_WE, tbl[i].we);
            chk($sformatf("v%0d_cpu_rvalid", i), cpu_rvalid, tbl[i].crv);
            chk($sformatf("v%0d_ext_rvalid", i), ext_rvalid, tbl[i].erv);
        end

        // Locked burst of three writes behind a contending CPU
        @(negedge clk);
        idle_inputs();
        cpu_req = 1'b1; cpu_addr = 32'h40;
        ext_req = 1'b1; ext_we = 1'b1; ext_lock = 1'b1; ext_addr = 32'h0; ext_wdata = 32'd1;
        #1;
        waits = 0;
        while (!ext_gnt && waits < 10) begin
            waits++;
            @(negedge clk);
            #1;
        end
        chk("t3_fair_wait", waits, MAX_WAIT);
        chk("t3_ext_gnt0", ext_gnt, 1);
        chk("t3_stall0", stall, 1);
        chk("t3_mem_we0", mem_WE, 1);
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            ext_addr = 32'(i * 4); ext_wdata = 32'(i + 1);
            #1;
            chk($sformatf("t3_ext_gnt%0d", i), ext_gnt, 1);
            chk($sformatf("t3_cpu_gnt%0d", i), cpu_gnt, 0);
            chk($sformatf("t3_stall%0d", i), stall, 1);
            chk($sformatf("t3_mem_we%0d", i), mem_WE, 1);
        end
        @(negedge clk);
        ext_req = 1'b0; ext_lock = 1'b0;
        #1;
        chk("t3_cpu_after", cpu_gnt, 1);
        chk("t3_stall_after", stall, 0);
        @(negedge clk);
        cpu_req = 1'b0;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h0;
        #1;
        chk("t3_rd_gnt", ext_gnt, 1);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (i < 3) ext_addr = 32'(i * 4);
            else ext_req = 1'b0;
            #1;
            chk($sformatf("t3_rb_rvalid%0d", i), ext_rvalid, 1);
            chk($sformatf("t3_rb_rdata%0d", i), ext_rdata, 32'(i));
        end

        // External write produces no read return; then idle
        @(negedge clk);
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h20; ext_wdata = 32'h55;
        #1;
        chk("t4_ext_gnt", ext_gnt, 1);
        chk("t4_mem_we", mem_WE, 1);
        chk("t4_mem_a", mem_A, 32'h20);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("t4_no_rvalid", ext_rvalid, 0);
        chk("t6_cpu_gnt", cpu_gnt, 0);
        chk("t6_ext_gnt", ext_gnt, 0);
        chk("t6_stall", stall, 0);
        chk("t6_mem_we", mem_WE, 0);
        chk("t6_cpu_rvalid", cpu_rvalid, 0);

        // Reset in the middle of a locked read burst
        @(negedge clk);
        ext_req = 1'b1; ext_we = 1'b0; ext_lock = 1'b1; ext_addr = 32'h4;
        #1;
        chk("t5_ext_gnt", ext_gnt, 1);
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = 32'h40; ext_addr = 32'h8;
        #1;
        chk("t5_locked_cpu_gnt", cpu_gnt, 0);
        chk("t5_rvalid_before", ext_rvalid, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_rvalid_rst", ext_rvalid, 0);
        chk("t5_rdata_rst", ext_rdata, 0);
        chk("t5_ext_gnt_rst", ext_gnt, 0);
        chk("t5_stall_rst", stall, 0);
        @(negedge clk);
        rst_n = 1'b1; ext_lock = 1'b0;
        #1;
        chk("t5_cpu_first", cpu_gnt, 1);
        chk("t5_ext_refused", ext_gnt, 0);
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        chk("t5_ext_then", ext_gnt, 1);
        @(negedge clk);
        idle_inputs();

        // Randomized traffic against a reference model
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_refused = 0; m_burst = 0; cpu_pend = 0; ext_pend = 0;
        exp_crv = 0; exp_erv = 0; exp_crd = '0; exp_erd = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (!cpu_pend) begin
                cpu_req   = ($urandom_range(0, 2) != 0);
                cpu_we    = ($urandom_range(0, 1) == 1);
                cpu_addr  = 32'($urandom_range(0, 63)) << 2;
                cpu_wdata = $urandom;
            end
            if (!ext_pend) begin
                ext_req   = ($urandom_range(0, 1) == 1);
                ext_we    = ($urandom_range(0, 1) == 1);
                ext_lock  = ($urandom_range(0, 1) == 1);
                ext_addr  = 32'($urandom_range(0, 63)) << 2;
                ext_wdata = $urandom;
            end
            #1;
            e = m_burst ? ext_req : (ext_req && (!cpu_req || m_refused == MAX_WAIT));
            c = cpu_req && !e;
            chk("rnd_cpu_gnt", cpu_gnt, c);
            chk("rnd_ext_gnt", ext_gnt, e);
            chk("rnd_stall", stall, cpu_req && !c);
            chk("rnd_mem_we", mem_WE, e ? ext_we : (c && cpu_we));
            chk("rnd_mem_a", mem_A, e ? ext_addr : cpu_addr);
            if (e && ext_we) chk("rnd_mem_wd_ext", mem_WD, ext_wdata);
            if (c && cpu_we) chk("rnd_mem_wd_cpu", mem_WD, cpu_wdata);
            chk("rnd_cpu_rvalid", cpu_rvalid, exp_crv);
            chk("rnd_cpu_rdata", cpu_rdata, exp_crd);
            chk("rnd_ext_rvalid", ext_rvalid, exp_erv);
            chk("rnd_ext_rdata", ext_rdata, exp_erd);

            exp_crv = c && !cpu_we;
            if (exp_crv) exp_crd = mem_read(cpu_addr);
            exp_erv = e && !ext_we;
            if (exp_erv) exp_erd = mem_read(ext_addr);
            if (e) begin
                m_refused = 0;
                m_burst   = ext_lock;
            end else if (!ext_req) begin
                m_refused = 0;
                m_burst   = 0;
            end else begin
                m_refused++;
            end
            cpu_pend = cpu_req && !c;
            ext_pend = ext_req && !e;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
